// File: rtl/jtag_tap_pkg.sv
// Shared types and default constants for the behavioural JTAG TAP model.
// Holds the TAP state enum, default opcodes and the default IDCODE value.
package jtag_tap_pkg;

    typedef enum logic [3:0] {
        TLR    = 4'h0,
        RTI    = 4'h1,
        SEL_DR = 4'h2,
        CAP_DR = 4'h3,
        SH_DR  = 4'h4,
        EX1_DR = 4'h5,
        PAU_DR = 4'h6,
        EX2_DR = 4'h7,
        UPD_DR = 4'h8,
        SEL_IR = 4'h9,
        CAP_IR = 4'hA,
        SH_IR  = 4'hB,
        EX1_IR = 4'hC,
        PAU_IR = 4'hD,
        EX2_IR = 4'hE,
        UPD_IR = 4'hF
    } tap_state_e;

    localparam logic [7:0] ER1_OP         = 8'h32;
    localparam logic [7:0] ER2_OP         = 8'h38;
    localparam logic [7:0] IDCODE_OP_DEF  = 8'hE0;
    localparam logic [7:0] BYPASS_OP      = 8'hFF;
    localparam logic [7:0] IR_CAPTURE_DEF = 8'h01;

    localparam logic [31:0] IDCODE_DEF = 32'h41111043;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 16-state TAP controller, clocked on posedge tck.
// Ports: tck_i, rst_i, tms_i in; one-hot state decodes (*_o) out.
module jtag_tap_fsm
    import jtag_tap_pkg::*;
(
    input  logic tck_i,
    input  logic rst_i,
    input  logic tms_i,
    output logic tlr_o,
    output logic rti_o,
    output logic cap_dr_o,
    output logic sh_dr_o,
    output logic upd_dr_o,
    output logic cap_ir_o,
    output logic sh_ir_o,
    output logic upd_ir_o
);

    tap_state_e state_q;
    tap_state_e state_d;

    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tlr_o    = 1'b0;
        rti_o    = 1'b0;
        cap_dr_o = 1'b0;
        sh_dr_o  = 1'b0;
        upd_dr_o = 1'b0;
        cap_ir_o = 1'b0;
        sh_ir_o  = 1'b0;
        upd_ir_o = 1'b0;
        unique case (state_q)
            TLR: begin
                tlr_o   = 1'b1;
                state_d = tms_i ? TLR : RTI;
            end
            RTI: begin
                rti_o   = 1'b1;
                state_d = tms_i ? SEL_DR : RTI;
            end
            SEL_DR: state_d = tms_i ? SEL_IR : CAP_DR;
            CAP_DR: begin
                cap_dr_o = 1'b1;
                state_d  = tms_i ? EX1_DR : SH_DR;
            end
            SH_DR: begin
                sh_dr_o = 1'b1;
                state_d = tms_i ? EX1_DR : SH_DR;
            end
            EX1_DR: state_d = tms_i ? UPD_DR : PAU_DR;
            PAU_DR: state_d = tms_i ? EX2_DR : PAU_DR;
            EX2_DR: state_d = tms_i ? UPD_DR : SH_DR;
            UPD_DR: begin
                upd_dr_o = 1'b1;
                state_d  = tms_i ? SEL_DR : RTI;
            end
            SEL_IR: state_d = tms_i ? TLR : CAP_IR;
            CAP_IR: begin
                cap_ir_o = 1'b1;
                state_d  = tms_i ? EX1_IR : SH_IR;
            end
            SH_IR: begin
                sh_ir_o = 1'b1;
                state_d = tms_i ? EX1_IR : SH_IR;
            end
            EX1_IR: state_d = tms_i ? UPD_IR : PAU_IR;
            PAU_IR: state_d = tms_i ? EX2_IR : PAU_IR;
            EX2_IR: state_d = tms_i ? UPD_IR : SH_IR;
            UPD_IR: begin
                upd_ir_o = 1'b1;
                state_d  = tms_i ? SEL_DR : RTI;
            end
        endcase
    end

endmodule

// File: rtl/jtag_tap_multi_er.sv
// Behavioural JTAG TAP with IDCODE, BYPASS and NUM_ER user DR channels.
// Ports: tck/rst/tms/tdi in, tdo/tdo_en out, j* user-side strobes,
// jtdo per-channel user DR input, ir_value shadow for visibility.
module jtag_tap_multi_er
    import jtag_tap_pkg::*;
#(
    parameter int                         IR_LEN     = 8,
    parameter int                         NUM_ER     = 2,
    parameter logic [NUM_ER*IR_LEN-1:0]   ER_OPCODES = {ER2_OP, ER1_OP},
    parameter logic [NUM_ER-1:0]          ER_ENABLE  = 2'b11,
    parameter logic [IR_LEN-1:0]          IDCODE_OP  = IDCODE_OP_DEF,
    parameter logic [31:0]                IDCODE     = IDCODE_DEF,
    parameter logic [IR_LEN-1:0]          IR_CAPTURE = IR_CAPTURE_DEF
) (
    input  logic              tck,
    input  logic              rst,
    input  logic              tms,
    input  logic              tdi,
    output logic              tdo,
    output logic              tdo_en,
    output logic              jtck,
    output logic              jtdi,
    output logic              jshift,
    output logic              jupdate,
    output logic              jrstn,
    output logic [NUM_ER-1:0] jce,
    output logic [NUM_ER-1:0] jrti,
    input  logic [NUM_ER-1:0] jtdo,
    output logic [IR_LEN-1:0] ir_value
);

    logic tlr, rti, cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir;

    jtag_tap_fsm u_fsm (
        .tck_i    (tck),
        .rst_i    (rst),
        .tms_i    (tms),
        .tlr_o    (tlr),
        .rti_o    (rti),
        .cap_dr_o (cap_dr),
        .sh_dr_o  (sh_dr),
        .upd_dr_o (upd_dr),
        .cap_ir_o (cap_ir),
        .sh_ir_o  (sh_ir),
        .upd_ir_o (upd_ir)
    );

    logic [IR_LEN-1:0] ir_shadow_q;
    logic [IR_LEN-1:0] ir_shift_q;
    logic [31:0]       idcode_q;
    logic              bypass_q;
    logic              jtdi_q;
    logic              tdo_q;
    logic              tdo_en_q;
    logic              jrstn_q;

    logic [NUM_ER-1:0] er_sel;
    logic              er_any;
    logic              idcode_sel;
    logic              bypass_sel;
    logic              dr_lsb;

    // Instruction decode; scanning upward with a hit flag makes the
    // lowest-numbered channel win when two share an opcode.
    always_comb begin
        er_sel = '0;
        er_any = 1'b0;
        for (int k = 0; k < NUM_ER; k++) begin
            if (!er_any && ER_ENABLE[k] &&
                ir_shadow_q == ER_OPCODES[k*IR_LEN +: IR_LEN]) begin
                er_sel[k] = 1'b1;
                er_any    = 1'b1;
            end
        end
        idcode_sel = !er_any && (ir_shadow_q == IDCODE_OP);
        bypass_sel = !er_any && !idcode_sel;
    end

    always_comb begin
        dr_lsb = bypass_q;
        if (er_any) begin
            dr_lsb = |(jtdo & er_sel);
        end else if (idcode_sel) begin
            dr_lsb = idcode_q[0];
        end
    end

    // Instruction register: shift path plus shadow.
    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            ir_shadow_q <= IDCODE_OP;
            ir_shift_q  <= '0;
        end else begin
            if (tlr) begin
                ir_shadow_q <= IDCODE_OP;
            end else if (upd_ir) begin
                ir_shadow_q <= ir_shift_q;
            end
            if (cap_ir) begin
                ir_shift_q <= IR_CAPTURE;
            end else if (sh_ir) begin
                ir_shift_q <= {tdi, ir_shift_q[IR_LEN-1:1]};
            end
        end
    end

    // Built-in data registers.
    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            idcode_q <= '0;
            bypass_q <= 1'b0;
            jtdi_q   <= 1'b0;
        end else begin
            jtdi_q <= tdi;
            if (idcode_sel) begin
                if (cap_dr) begin
                    idcode_q <= IDCODE;
                end else if (sh_dr) begin
                    idcode_q <= {tdi, idcode_q[31:1]};
                end
            end
            if (bypass_sel) begin
                if (cap_dr) begin
                    bypass_q <= 1'b0;
                end else if (sh_dr) begin
                    bypass_q <= tdi;
                end
            end
        end
    end

    // Falling-edge output stage; tdo holds outside the shift states.
    always_ff @(negedge tck or posedge rst) begin
        if (rst) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
            jrstn_q  <= 1'b0;
        end else begin
            tdo_en_q <= sh_ir | sh_dr;
            jrstn_q  <= !tlr;
            if (sh_ir) begin
                tdo_q <= ir_shift_q[0];
            end else if (sh_dr) begin
                tdo_q <= dr_lsb;
            end
        end
    end

    assign tdo      = tdo_q;
    assign tdo_en   = tdo_en_q;
    assign jtck     = tck;
    assign jtdi     = jtdi_q;
    assign jrstn    = jrstn_q;
    assign jshift   = sh_dr & er_any;
    assign jupdate  = upd_dr & er_any;
    assign jce      = er_sel & {NUM_ER{cap_dr | sh_dr}};
    assign jrti     = er_sel & {NUM_ER{rti}};
    assign ir_value = ir_shadow_q;

endmodule

// File: tb/tb_jtag_tap_multi_er.sv
// Scoreboard bench for jtag_tap_multi_er: two builds (default, 4ch/10bit).
// Driver pushes expected tdo bits; a negedge monitor pops and compares.
module tb_jtag_tap_multi_er;

    logic       tck = 1'b0;
    logic       rst;
    logic       tms_r;
    logic       tdi_r;
    logic [3:0] jtdo_r;
    logic       cur;

    always #5 tck = ~tck;

    logic       tdo_a, tdo_en_a, jtck_a, jtdi_a, jshift_a, jupdate_a, jrstn_a;
    logic [1:0] jce_a, jrti_a;
    logic [7:0] ir_a;
    logic       tdo_b, tdo_en_b, jtck_b, jtdi_b, jshift_b, jupdate_b, jrstn_b;
    logic [3:0] jce_b, jrti_b;
    logic [9:0] ir_b;
    logic       tms_a, tms_b;

    assign tms_a = cur ? 1'b1 : tms_r;
    assign tms_b = cur ? tms_r : 1'b1;

    jtag_tap_multi_er dut_a (
        .tck(tck), .rst(rst), .tms(tms_a), .tdi(tdi_r),
        .tdo(tdo_a), .tdo_en(tdo_en_a), .jtck(jtck_a), .jtdi(jtdi_a),
        .jshift(jshift_a), .jupdate(jupdate_a), .jrstn(jrstn_a),
        .jce(jce_a), .jrti(jrti_a), .jtdo(jtdo_r[1:0]), .ir_value(ir_a)
    );

    jtag_tap_multi_er #(
        .IR_LEN(10), .NUM_ER(4),
        .ER_OPCODES({10'h15A, 10'h0A5, 10'h038, 10'h032}),
        .ER_ENABLE(4'b1011), .IDCODE_OP(10'h0E0),
        .IDCODE(32'h2468ACE1), .IR_CAPTURE(10'h1C5)
    ) dut_b (
        .tck(tck), .rst(rst), .tms(tms_b), .tdi(tdi_r),
        .tdo(tdo_b), .tdo_en(tdo_en_b), .jtck(jtck_b), .jtdi(jtdi_b),
        .jshift(jshift_b), .jupdate(jupdate_b), .jrstn(jrstn_b),
        .jce(jce_b), .jrti(jrti_b), .jtdo(jtdo_r), .ir_value(ir_b)
    );

    logic       tdo_m, tdo_en_m, jtck_m, jtdi_m, jshift_m, jupdate_m, jrstn_m;
    logic [3:0] jce_m, jrti_m;
    logic [9:0] ir_m;

    assign tdo_m     = cur ? tdo_b     : tdo_a;
    assign tdo_en_m  = cur ? tdo_en_b  : tdo_en_a;
    assign jtck_m    = cur ? jtck_b    : jtck_a;
    assign jtdi_m    = cur ? jtdi_b    : jtdi_a;
    assign jshift_m  = cur ? jshift_b  : jshift_a;
    assign jupdate_m = cur ? jupdate_b : jupdate_a;
    assign jrstn_m   = cur ? jrstn_b   : jrstn_a;
    assign jce_m     = cur ? jce_b     : {2'b00, jce_a};
    assign jrti_m    = cur ? jrti_b    : {2'b00, jrti_a};
    assign ir_m      = cur ? ir_b      : {2'b00, ir_a};

    // Reference model: what the current build should do, in spec terms.
    int          ir_len;
    int          nch;
    logic [31:0] idop, capv, idv, m_ir;
    logic [31:0] ops[4];
    logic [3:0]  en;

    bit exp_q[$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sel();
        for (int k = 0; k < nch; k++)
            if (en[k] && ops[k] == m_ir) return k;
        return -1;
    endfunction

    function automatic logic [31:0] oh(input int s);
        return (s < 0) ? 32'd0 : (32'd1 << s);
    endfunction

    task automatic set_model(input logic c);
        cur = c;
        if (!c) begin
            ir_len = 8;  nch = 2;
            idop = 32'h0E0; capv = 32'h01; idv = 32'h41111043;
            ops[0] = 32'h32; ops[1] = 32'h38; ops[2] = 0; ops[3] = 0;
            en = 4'b0011;
        end else begin
            ir_len = 10; nch = 4;
            idop = 32'h0E0; capv = 32'h1C5; idv = 32'h2468ACE1;
            ops[0] = 32'h032; ops[1] = 32'h038;
            ops[2] = 32'h0A5; ops[3] = 32'h15A;
            en = 4'b1011;
        end
        m_ir = idop;
    endtask

    // Monitor: every negedge where tdo_en is up carries one scan bit.
    always @(negedge tck) begin
        #1;
        if (tdo_en_m === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL tdo_unexpected: tdo_en=1 with no bit expected at %0t",
                         $time);
            end else begin
                chk("tdo", {31'd0, tdo_m}, {31'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic step(input logic m, input logic d);
        tms_r = m;
        tdi_r = d;
        @(posedge tck);
        #1;
        chk("jtdi", {31'd0, jtdi_m}, {31'd0, d});
        chk("jtck", {31'd0, jtck_m}, 32'd1);
    endtask

    task automatic scan_ir(input logic [31:0] v);
        logic [31:0] old;
        logic [31:0] mask;
        old  = m_ir;
        mask = (32'd1 << ir_len) - 1;
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < ir_len; i++) begin
            exp_q.push_back(capv[i]);
            step(i == ir_len - 1, v[i]);
        end
        step(1, 0);
        chk("ir_hold_in_upd", {22'd0, ir_m}, old);
        step(0, 0);
        m_ir = v & mask;
        chk("ir_after_upd", {22'd0, ir_m}, m_ir);
        chk("jrti", {28'd0, jrti_m}, oh(sel()));
    endtask

    task automatic scan_dr(input int n);
        int   s;
        bit   hist[$];
        logic d, e;
        s = sel();
        step(1, 0); step(0, 0);
        chk("jce_cap", {28'd0, jce_m}, oh(s));
        chk("jshift_cap", {31'd0, jshift_m}, 32'd0);
        step(0, 0);
        for (int i = 0; i < n; i++) begin
            d      = 1'($urandom);
            jtdo_r = 4'($urandom);
            if (s >= 0)          e = jtdo_r[s];
            else if (m_ir == idop) e = (i < 32) ? idv[i] : hist[i-32];
            else                 e = (i == 0) ? 1'b0 : hist[i-1];
            exp_q.push_back(e);
            chk("jce_sh", {28'd0, jce_m}, oh(s));
            chk("jshift_sh", {31'd0, jshift_m}, {31'd0, s >= 0});
            hist.push_back(d);
            step(i == n - 1, d);
        end
        chk("jshift_ex", {31'd0, jshift_m}, 32'd0);
        step(1, 0);
        chk("jupdate_upd", {31'd0, jupdate_m}, {31'd0, s >= 0});
        step(0, 0);
        chk("jupdate_rti", {31'd0, jupdate_m}, 32'd0);
        chk("jrti_after_dr", {28'd0, jrti_m}, oh(s));
        chk("jce_rti", {28'd0, jce_m}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        rst = 1'b1; tms_r = 1'b1; tdi_r = 1'b0; jtdo_r = '0;
        set_model(1'b0);
        #1;
        chk("rst_ir", {22'd0, ir_m}, idop);
        chk("rst_tdo_en", {31'd0, tdo_en_m}, 32'd0);
        chk("rst_jrstn", {31'd0, jrstn_m}, 32'd0);
        chk("rst_jtdi", {31'd0, jtdi_m}, 32'd0);
        chk("rst_jce", {28'd0, jce_m}, 32'd0);
        repeat (3) @(posedge tck);
        #1;
        rst = 1'b0;
        repeat (5) step(1, 0);
        chk("tlr_ir", {22'd0, ir_m}, idop);
        chk("tlr_jrti", {28'd0, jrti_m}, 32'd0);
        @(negedge tck); #1;
        chk("tlr_jrstn", {31'd0, jrstn_m}, 32'd0);
        chk("tlr_tdo_en", {31'd0, tdo_en_m}, 32'd0);
        step(0, 0);
        @(negedge tck); #1;
        chk("rti_jrstn", {31'd0, jrstn_m}, 32'd1);

        scan_dr(40);
        scan_ir(32'h32);
        scan_dr(8);
        scan_ir(32'h38);
        scan_ir(32'hFF);
        scan_dr(3);
        for (int it = 0; it < 12; it++) begin
            case ($urandom_range(0, 4))
                0: v = 32'h32;
                1: v = 32'h38;
                2: v = 32'hE0;
                3: v = 32'hFF;
                default: v = $urandom;
            endcase
            scan_ir(v);
            scan_dr($urandom_range(1, 40));
        end

        // Reset in the middle of an IR shift of 0x38.
        v = 32'h38;
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(capv[i]);
            step(0, v[i]);
        end
        rst = 1'b1;
        #1;
        m_ir = idop;
        chk("abort_ir", {22'd0, ir_m}, idop);
        chk("abort_jce", {28'd0, jce_m}, 32'd0);
        chk("abort_jupdate", {31'd0, jupdate_m}, 32'd0);
        @(negedge tck); #1;
        chk("abort_tdo_en", {31'd0, tdo_en_m}, 32'd0);
        chk("abort_jrstn", {31'd0, jrstn_m}, 32'd0);
        @(posedge tck); #1;
        tms_r = 1'b1;
        rst = 1'b0;
        step(0, 0);
        chk("abort_rti_ir", {22'd0, ir_m}, idop);
        chk("abort_rti_jrti", {28'd0, jrti_m}, 32'd0);

        // Five tms=1 clocks reload the IDCODE opcode.
        scan_ir(32'h32);
        repeat (5) step(1, 0);
        m_ir = idop;
        chk("tlr_reload_ir", {22'd0, ir_m}, idop);
        step(0, 0);

        // Second build: 4 channels, ch2 disabled.
        set_model(1'b1);
        step(0, 0);
        scan_dr(36);
        scan_ir(32'h0A5);
        scan_dr(5);
        scan_ir(32'h15A);
        scan_dr(6);
        scan_ir(32'h3FF);
        scan_dr(4);
        for (int it = 0; it < 6; it++) begin
            case ($urandom_range(0, 3))
                0: v = ops[$urandom_range(0, 3)];
                1: v = 32'h0E0;
                default: v = $urandom;
            endcase
            scan_ir(v);
            scan_dr($urandom_range(1, 36));
        end

        repeat (3) step(0, 0);
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_tap_multi_er.md
Name: jtag_tap_multi_er

Overview:
Parametrised behavioural JTAG TAP model for simulation, the next generation of the two-channel ECP5 JTAGG stand-in. It adds a full 16-state TAP FSM with configurable IR length, NUM_ER user data-register channels, IDCODE and BYPASS registers, and an explicit TDO enable. It sits between the testbench JTAG driver and the debug core's JTAG-facing modules, and is never synthesised.

Parameters:
IR_LEN, 8, instruction register width (>=2)
NUM_ER, 2, number of user ER channels (>=1)
ER_OPCODES, {8'h38,8'h32}, packed NUM_ER*IR_LEN opcodes, channel k at slice k (ch0=0x32, ch1=0x38)
ER_ENABLE, 2'b11, per-channel enable mask; a disabled channel's opcode decodes as BYPASS
IDCODE_OP, 8'hE0, IDCODE instruction opcode
IDCODE, 32'h41111043, value captured into the IDCODE DR
IR_CAPTURE, 8'h01, value loaded into the IR shift register in Capture-IR

Ports:
tck  in  1  JTAG clock, the block's only clock
rst  in  1  asynchronous active-high reset
tms  in  1  test mode select
tdi  in  1  test data in
tdo  out  1  test data out, registered on negedge tck
tdo_en  out  1  high while tdo is valid (Shift-IR/Shift-DR); the top level performs tristating
jtck  out  1  equals tck
jtdi  out  1  tdi registered on posedge tck
jshift  out  1  Shift-DR and an ER channel selected
jupdate  out  1  Update-DR and an ER channel selected
jrstn  out  1  active-low reset to user logic, registered on negedge
jce  out  NUM_ER  per-channel Capture-DR|Shift-DR and channel selected
jrti  out  NUM_ER  per-channel Run-Test/Idle and channel selected
jtdo  in  NUM_ER  per-channel user DR serial output
ir_value  out  IR_LEN  current IR shadow, for bench visibility

Behaviour:
- rst asserted (async): state=TEST_LOGIC_RESET; IR shadow=IDCODE_OP; IR shift=0; IDCODE DR=0; bypass=0; jtdi=0; tdo=0; tdo_en=0; jrstn=0. All other outputs are combinational and therefore 0/inactive.
- FSM states: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR. IEEE 1149.1 transitions occur on posedge tck. Five consecutive tms=1 clocks reach TLR from any state.
- In TLR: IR shadow reloads IDCODE_OP on every posedge (synchronous, in addition to rst).
- IR: CAP_IR loads IR_CAPTURE; SH_IR shifts {tdi, ir[IR_LEN-1:1]}; UPD_IR copies shift to shadow. The IR is never modified in pause/exit states.
- Decode (combinational from shadow): channel k is selected if shadow==ER_OPCODES[k] and ER_ENABLE[k]. On a duplicate opcode, the lowest k wins. Otherwise IDCODE is selected if shadow==IDCODE_OP; otherwise BYPASS (includes all-ones).
- IDCODE DR: CAP_DR loads IDCODE; SH_DR shifts right with tdi into bit 31, LSB first out.
- BYPASS DR: CAP_DR loads 0; SH_DR loads tdi.
- ER channels: data is owned by user logic. The block only drives jce/jshift/jupdate/jrti and muxes jtdo[k].
- negedge tck: tdo_en <= (state==SH_IR || state==SH_DR). tdo <= ir_shift[0] in SH_IR, else the selected DR LSB / jtdo[k] / bypass in SH_DR. tdo holds its value otherwise. jrstn <= (state!=TLR).
- Latency: the first tdo bit of a shift is valid from the negedge following entry into SH_*. jtdi lags tdi by one posedge.
- rst mid-shift: abort with no update. The shadow becomes IDCODE_OP and the partial IR shift is discarded.

Decomposition:
- Package jtag_tap_pkg: 4-bit state enum and state encodings, default opcodes (ER1 0x32, ER2 0x38, IDCODE 0xE0, BYPASS all-ones), default IDCODE constant.
- Sub-module jtag_tap_fsm: tck, rst, tms in; one-hot state-decode outputs out (TLR, RTI, CAP/SH/UPD for IR and DR). The parent holds the registers, decode, and tdo mux.

Test Plan:
- rst pulse, then 5 tck with tms=1 -> state TLR, ir_value=0xE0, jrstn=0 after the next negedge, tdo_en=0.
- From RTI, go to SH_DR and shift 32 bits with tdi=0 -> tdo LSB-first yields 0x41111043, tdo_en=1 for exactly 32 negedges.
- Load IR 0x32 (capture shifts out 0x01 LSB-first), then enter CAP_DR/SH_DR for 8 clocks -> jce=2'b01 in CAP and SH, jshift=1 for 8 cycles, tdo follows jtdo[0]; UPD_DR -> jupdate=1 for one cycle.
- Load IR 0x38 and park in RTI -> jrti=2'b10; load 0xFF and shift 1,0,1 -> tdo returns 1,0,1 delayed one bit (bypass), jce=0.
- Build with NUM_ER=4, IR_LEN=10, ER_ENABLE=4'b1011 and load the ch2 opcode -> BYPASS behaviour, jce=0; load the ch3 opcode -> jce=4'b1000.
- Assert rst during SH_IR after 4 of 8 bits of 0x38 -> immediate TLR, ir_value=0xE0, no jupdate/jce activity.
